// File: rtl/playback_sequencer.sv
// playback_sequencer
// Plays the stored Simon colour pattern on the four game LEDs. Each step is a
// dark fetch cycle, a dark RAM-latency cycle, an on-time and a dark gap. The
// on-time and gap are the base durations shifted right by the speed level.
// Timing comes from a single cycle counter in the clk domain. led, done and
// rd_addr are driven straight from flops.
module playback_sequencer #(
  parameter int unsigned BASE_ON  = 50_000_000,
  parameter int unsigned BASE_GAP = 25_000_000,
  parameter int unsigned CNT_W    = 27,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   length,
  input  logic [2:0]        level,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic [3:0]        led,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    ON,
    GAP,
    FINISH
  } state_t;

  localparam logic [CNT_W-1:0] BASE_ON_C  = CNT_W'(BASE_ON);
  localparam logic [CNT_W-1:0] BASE_GAP_C = CNT_W'(BASE_GAP);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W:0]  IDX_ONE    = (ADDR_W+1)'(1);

  // Level-scaled duration: logical right shift, never shorter than one cycle.
  function automatic logic [CNT_W-1:0] scale_dur(input logic [CNT_W-1:0] base,
                                                 input logic [2:0]       lvl);
    logic [CNT_W-1:0] shifted;
    shifted = base >> lvl;
    return (shifted == '0) ? CNT_ONE : shifted;
  endfunction

  state_t            state_q,   state_d;
  logic [ADDR_W:0]   len_q,     len_d;
  logic [ADDR_W:0]   idx_q,     idx_d;
  logic [CNT_W-1:0]  on_q,      on_d;
  logic [CNT_W-1:0]  gap_q,     gap_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [1:0]        colour_q,  colour_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [3:0]        led_q,     led_d;
  logic              done_q,    done_d;

  // idx is one bit wider than the address so a full-depth pattern can end
  // without the counter wrapping back onto zero.
  logic [ADDR_W:0]   idx_inc;
  assign idx_inc = idx_q + IDX_ONE;

  // Next-state and next-output computation for the playback sequence.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    on_d      = on_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    colour_d  = colour_q;
    rd_addr_d = rd_addr_q;
    led_d     = '0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // abort and start together: abort wins, so start is dropped.
        if (start && !abort) begin
          if (length == '0) begin
            // Nothing to play: acknowledge at once and stay idle.
            done_d = 1'b1;
          end else begin
            len_d     = length;
            on_d      = scale_dur(BASE_ON_C, level);
            gap_d     = scale_dur(BASE_GAP_C, level);
            idx_d     = '0;
            rd_addr_d = '0;
            state_d   = FETCH;
          end
        end
      end

      // rd_addr already holds idx; the RAM registers it at the end of this cycle.
      FETCH: begin
        state_d = WAIT;
      end

      // RAM data is valid now; latch the colour and light it from the next cycle.
      WAIT: begin
        colour_d = rd_data;
        led_d    = 4'b0001 << rd_data;
        cnt_d    = on_q - CNT_ONE;
        state_d  = ON;
      end

      ON: begin
        if (cnt_q == '0) begin
          cnt_d   = gap_q - CNT_ONE;
          state_d = GAP;
        end else begin
          led_d = 4'b0001 << colour_q;
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      GAP: begin
        if (cnt_q == '0) begin
          idx_d = idx_inc;
          if (idx_inc == len_q) begin
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
            // Only move the address when another fetch follows, so the last
            // address played stays on the bus instead of wrapping to zero.
            rd_addr_d = idx_inc[ADDR_W-1:0];
            state_d   = FETCH;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything once a run is in progress: dark LEDs, no done.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      led_d   = '0;
      done_d  = 1'b0;
    end
  end

  // State, latched run parameters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      on_q      <= '0;
      gap_q     <= '0;
      cnt_q     <= '0;
      colour_q  <= '0;
      rd_addr_q <= '0;
      led_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      on_q      <= on_d;
      gap_q     <= gap_d;
      cnt_q     <= cnt_d;
      colour_q  <= colour_d;
      rd_addr_q <= rd_addr_d;
      led_q     <= led_d;
      done_q    <= done_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign led     = led_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed bench for playback_sequencer with short durations (BASE_ON=8,
// BASE_GAP=4). A synchronous-read pattern RAM model feeds rd_data. Cycle 1
// is the first cycle after the edge that samples start.
module tb_playback_sequencer;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   length;
  logic [2:0]        level;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_data;
  logic [3:0]        led;
  logic              busy;
  logic              done;

  logic [1:0] ram [32];

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle capture of the last run; index c-1 holds cycle c.
  logic [3:0]        q_led  [$];
  logic              q_busy [$];
  logic              q_done [$];
  logic [ADDR_W-1:0] q_addr [$];
  int                done_cyc;

  playback_sequencer #(
    .BASE_ON (8),
    .BASE_GAP(4),
    .CNT_W   (CNT_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .length (length),
    .level  (level),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .led    (led),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read pattern RAM.
  always @(posedge clk) rd_data <= ram[rd_addr];

  // Pattern: 2,0,3,1 repeated, each group of four XORed with its group number.
  function automatic logic [1:0] pat_val(input int i);
    logic [1:0] b;
    case (i % 4)
      0:       b = 2'd2;
      1:       b = 2'd0;
      2:       b = 2'd3;
      default: b = 2'd1;
    endcase
    return b ^ 2'(i / 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start and capture outputs until one cycle past done or max_cyc.
  // inj_cyc != 0 pulses a second start (length=1, level=3) at that cycle.
  task automatic play(input logic [ADDR_W:0] len, input logic [2:0] lvl,
                      input int max_cyc, input int inj_cyc);
    q_led.delete();
    q_busy.delete();
    q_done.delete();
    q_addr.delete();
    done_cyc = 0;
    length   = len;
    level    = lvl;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      q_led.push_back(led);
      q_busy.push_back(busy);
      q_done.push_back(done);
      q_addr.push_back(rd_addr);
      if (done === 1'b1 && done_cyc == 0) done_cyc = c;
      if (done_cyc != 0 && c == done_cyc + 1) break;
      if (c == inj_cyc) begin
        start  = 1'b1;
        length = 1;
        level  = 3'd3;
      end
      tick();
      start = 1'b0;
    end
  endtask

  // Expected LED in cycle c: each step is FETCH, WAIT, on cycles lit, gap dark.
  function automatic logic [3:0] exp_led(input int c, input int on, input int gap);
    int p;
    int k;
    int o;
    p = on + gap + 2;
    k = (c - 1) / p;
    o = (c - 1) % p;
    if (o >= 2 && o < 2 + on) return 4'b0001 << ram[k];
    return 4'b0000;
  endfunction

  // First captured cycle whose led/busy/done differs from the timing model, or 0.
  function automatic int first_bad(input int on, input int gap, input int len);
    int ed;
    logic [3:0] el;
    ed = 1 + len * (on + gap + 2);
    for (int c = 1; c <= ed + 1; c++) begin
      if (c > q_led.size()) return c;
      el = (c <= ed) ? exp_led(c, on, gap) : 4'b0000;
      if (q_led[c-1] !== el) return c;
      if (q_busy[c-1] !== (c <= ed)) return c;
      if (q_done[c-1] !== (c == ed)) return c;
    end
    return 0;
  endfunction

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    length = '0;
    level  = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (led !== 4'b0000) begin n_fail++; $display("FAIL reset_led got %b want 0000", led); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int fb;
    play(6'd4, 3'd0, 80, 0);
    n_tests++; if (done_cyc !== 57) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 57", done_cyc); end
    n_tests++; if (q_led[2] !== 4'b0100) begin n_fail++; $display("FAIL basic_led_c3 got %b want 0100", q_led[2]); end
    n_tests++; if (q_led[10] !== 4'b0000) begin n_fail++; $display("FAIL basic_led_c11 got %b want 0000", q_led[10]); end
    n_tests++; if (q_led[16] !== 4'b0001) begin n_fail++; $display("FAIL basic_led_c17 got %b want 0001", q_led[16]); end
    n_tests++; if (q_led[30] !== 4'b1000) begin n_fail++; $display("FAIL basic_led_c31 got %b want 1000", q_led[30]); end
    n_tests++; if (q_led[44] !== 4'b0010) begin n_fail++; $display("FAIL basic_led_c45 got %b want 0010", q_led[44]); end
    fb = first_bad(8, 4, 4);
    n_tests++; if (fb !== 0) begin n_fail++; $display("FAIL basic_trace first bad cycle %0d want none", fb); end
  endtask

  task automatic test_level();
    int fb;
    play(6'd4, 3'd2, 40, 0);
    n_tests++; if (done_cyc !== 21) begin n_fail++; $display("FAIL level2_done_cycle got %0d want 21", done_cyc); end
    fb = first_bad(2, 1, 4);
    n_tests++; if (fb !== 0) begin n_fail++; $display("FAIL level2_trace first bad cycle %0d want none", fb); end
    play(6'd4, 3'd7, 40, 0);
    n_tests++; if (done_cyc !== 17) begin n_fail++; $display("FAIL level7_done_cycle got %0d want 17", done_cyc); end
    n_tests++; if (q_led[2] !== 4'b0100 || q_led[3] !== 4'b0000) begin
      n_fail++; $display("FAIL level7_on_gap got %b,%b want 0100,0000", q_led[2], q_led[3]);
    end
    fb = first_bad(1, 1, 4);
    n_tests++; if (fb !== 0) begin n_fail++; $display("FAIL level7_trace first bad cycle %0d want none", fb); end
  endtask

  task automatic test_len_zero();
    length = '0;
    level  = 3'd0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL len0_done got %b want 1", done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy got %b want 0", busy); end
    n_tests++; if (led !== 4'b0000) begin n_fail++; $display("FAIL len0_led got %b want 0000", led); end
    tick();
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL len0_after got done=%b busy=%b want 0,0", done, busy);
    end
  endtask

  task automatic test_len_max();
    int fb;
    int bad_addr;
    play(6'd32, 3'd0, 480, 0);
    n_tests++; if (done_cyc !== 449) begin n_fail++; $display("FAIL len32_done_cycle got %0d want 449", done_cyc); end
    fb = first_bad(8, 4, 32);
    n_tests++; if (fb !== 0) begin n_fail++; $display("FAIL len32_trace first bad cycle %0d want none", fb); end
    bad_addr = 0;
    for (int c = 1; c <= 448; c++) begin
      if (bad_addr == 0 && q_addr[c-1] !== 5'((c - 1) / 14)) bad_addr = c;
    end
    n_tests++; if (bad_addr !== 0) begin n_fail++; $display("FAIL len32_addr_walk first bad cycle %0d want none", bad_addr); end
    n_tests++; if (q_addr[448] !== 5'd31) begin n_fail++; $display("FAIL len32_addr_at_done got %0d want 31", q_addr[448]); end
  endtask

  task automatic test_abort();
    int seen_done;
    int fb;
    length = 6'd4;
    level  = 3'd0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (18) tick();
    // Cycle 19: inside the second step's on-time (colour 0).
    n_tests++; if (led !== 4'b0001) begin n_fail++; $display("FAIL abort_pre_led got %b want 0001", led); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++; if (led !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_next got led=%b busy=%b done=%b want 0000,0,0", led, busy, done);
    end
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done++;
      tick();
    end
    n_tests++; if (seen_done !== 0) begin n_fail++; $display("FAIL abort_quiet got %0d active cycles want 0", seen_done); end
    play(6'd4, 3'd0, 80, 0);
    fb = first_bad(8, 4, 4);
    n_tests++; if (fb !== 0 || done_cyc !== 57) begin
      n_fail++; $display("FAIL abort_restart first bad %0d done %0d want none,57", fb, done_cyc);
    end
  endtask

  task automatic test_ignored_start();
    int fb;
    play(6'd4, 3'd0, 80, 10);
    n_tests++; if (done_cyc !== 57) begin n_fail++; $display("FAIL ignstart_done_cycle got %0d want 57", done_cyc); end
    fb = first_bad(8, 4, 4);
    n_tests++; if (fb !== 0) begin n_fail++; $display("FAIL ignstart_trace first bad cycle %0d want none", fb); end
  endtask

  task automatic test_back_to_back();
    int fb;
    play(6'd1, 3'd7, 20, 0);
    n_tests++; if (done_cyc !== 5) begin n_fail++; $display("FAIL b2b_first_done got %0d want 5", done_cyc); end
    play(6'd1, 3'd7, 20, 0);
    fb = first_bad(1, 1, 1);
    n_tests++; if (fb !== 0 || done_cyc !== 5) begin
      n_fail++; $display("FAIL b2b_second first bad %0d done %0d want none,5", fb, done_cyc);
    end
  endtask

  task automatic test_async_reset();
    int fb;
    length = 6'd4;
    level  = 3'd0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (25) tick();
    // Cycle 26: gap of the second step, rd_addr = 1.
    n_tests++; if (led !== 4'b0000 || busy !== 1'b1 || rd_addr !== 5'd1) begin
      n_fail++; $display("FAIL areset_pre got led=%b busy=%b addr=%0d want 0000,1,1", led, busy, rd_addr);
    end
    #3;
    reset = 1'b1;
    #1;
    n_tests++; if (led !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || rd_addr !== 5'd0) begin
      n_fail++; $display("FAIL areset_immediate got led=%b busy=%b done=%b addr=%0d want 0000,0,0,0",
                         led, busy, done, rd_addr);
    end
    #2;
    reset = 1'b0;
    tick();
    play(6'd4, 3'd0, 80, 0);
    fb = first_bad(8, 4, 4);
    n_tests++; if (fb !== 0 || done_cyc !== 57) begin
      n_fail++; $display("FAIL areset_restart first bad %0d done %0d want none,57", fb, done_cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = pat_val(i);
    test_reset();
    test_basic();
    test_level();
    test_len_zero();
    test_len_max();
    test_abort();
    test_ignored_start();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/playback_sequencer.md
# playback_sequencer

Sequences playback of the stored Simon colour pattern to the four game LEDs at a level-dependent speed. It replaces the free-running divided clock with a single-clock-domain cycle counter, which makes each step's on-time and gap programmable and exact. It sits between the pattern RAM (synchronous read) and the LED drivers, and is started by the game FSM when the machine's turn begins.

## Interface
- BASE_ON, default 50_000_000: LED on-time in clk cycles at level 0 (0.5 s at 100 MHz).
- BASE_GAP, default 25_000_000: dark gap after each LED in clk cycles at level 0.
- CNT_W, default 27: duration counter width; must hold BASE_ON and BASE_GAP.
- ADDR_W, default 5: pattern address width; maximum pattern length is 2^ADDR_W.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle request to play; ignored unless idle.
- abort  in  1  synchronous; stops playback immediately.
- length  in  ADDR_W+1  number of steps to play, 0..2^ADDR_W; sampled with start.
- level  in  3  speed level 0..7; sampled with start.
- rd_addr  out  ADDR_W  pattern RAM read address.
- rd_data  in  2  colour index from RAM, valid the cycle after rd_addr is presented.
- led  out  4  one-hot LED drive, bit rd_data.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last step's gap completes.

## Operation
- The state machine has six states: IDLE, FETCH, WAIT, ON, GAP, FINISH.
- **IDLE:** on start=1 with length≠0:
  - latch len_q=length, on_q=max(BASE_ON>>level,1), gap_q=max(GAP>>level,1), where GAP is BASE_GAP;
  - set idx=0;
  - go to FETCH.
- **IDLE, start with length=0:** stay in IDLE and pulse done next cycle with busy low. This is the only case where done is asserted outside FINISH.
- **FETCH:** rd_addr=idx. Go to WAIT.
- **WAIT:** capture rd_data into colour_q at the end of the cycle. Load cnt=on_q−1. Go to ON.
- **ON:** led=1<<colour_q. Decrement cnt each cycle. When cnt==0, load cnt=gap_q−1 and go to GAP.
- **GAP:** led=0. Decrement cnt each cycle. When cnt==0, set idx=idx+1; go to FINISH if idx+1==len_q, else FETCH.
- **FINISH:** done=1 for this cycle. Go to IDLE.
- **start while busy:** ignored; latched values are unchanged.
- **abort=1 in any non-IDLE state:** next state is IDLE, led=0, and no done pulse. If abort and start occur together in IDLE, abort wins and start is ignored.
- **Outputs:** led, done and rd_addr are registered (driven from flops, no combinational path from inputs).
- **Arithmetic:**
  - the shift is a logical right shift on CNT_W bits, with a clamp to a minimum of 1 cycle;
  - idx is ADDR_W+1 bits, so length=2^ADDR_W terminates without wrapping;
  - rd_addr is idx[ADDR_W-1:0].

## Timing
- **Reset values:** state=IDLE, led=0, busy=0, done=0, rd_addr=0, idx=0, cnt=0.
- **Start latency:** start sampled high at edge 0 gives FETCH in cycle 1, WAIT in cycle 2, and the first LED in cycle 3 (led registered, visible after edge 3).
- **Step period:** on_q + gap_q + 2 cycles (FETCH and WAIT are dark).
- **Total playback:** start to done = 1 + len_q·(on_q+gap_q+2) cycles. done is high for exactly 1 cycle, then busy drops the following cycle.
- **Back-to-back runs:** a new start is accepted in the first IDLE cycle after FINISH.
- **Reset during playback:** all outputs return to their reset values asynchronously; no done pulse.

## Test plan
Bench parameters: BASE_ON=8, BASE_GAP=4, ADDR_W=5. Pattern RAM model preloaded with 2,0,3,1.

- **Basic playback:** start with length=4, level=0.
  - led=0100 for 8 cycles from cycle 3, dark 6 cycles, then 0001, 1000, 0010;
  - done pulses at cycle 1+4·14=57; busy high from cycle 1 through 57.
- **Level scaling:**
  - level=2 → on 2 cycles, gap 1 cycle;
  - level=7 → on 1 cycle and gap 1 cycle (clamped);
  - done at cycles 1+4·5=21 and 1+4·4=17 respectively.
- **Boundary lengths:**
  - length=0 → no led activity, busy stays 0, done pulses 1 cycle;
  - length=32 with RAM filled → rd_addr visits 0..31 once, and done occurs with no wrap back to 0.
- **Abort:** abort asserted during the 2nd step's ON state → led=0 and busy=0 the next cycle, no done; a fresh start then plays correctly from idx 0.
- **Ignored start:** start pulsed mid-run with length=1, level=3 → the run completes with the original length and timing.
- **Asynchronous reset:** reset asserted mid-GAP between clock edges → led, busy, done and rd_addr go to 0 immediately; after release, a start plays normally.
